// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: show-ahead circular FIFO of
// {instr, pc} pairs with a pipeline flush.
module instr_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   i_instr,
   input  logic [31:0]   i_pc,
   input  logic          i_valid,
   output logic          o_next,
   output logic [31:0]   o_instr,
   output logic [31:0]   o_pc,
   output logic          o_valid,
   input  logic          i_next,
   input  logic          c_flush,
   output logic [AW:0]   o_count
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          push;
   logic          pop;

   assign o_next  = (cnt != FULL);
   assign o_valid = (cnt != '0);
   assign o_count = cnt;
   assign push    = i_valid && o_next;
   assign pop     = o_valid && i_next;

   assign o_instr = mem[rp][63:32];
   assign o_pc    = mem[rp][31:0];

   // Storage is not reset; a flushed entry is never written.
   always_ff @(posedge clk) begin
      if (push && !c_flush)
         mem[wp] <= {i_instr, i_pc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (c_flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_instr_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   i_instr;
   logic [31:0]   i_pc;
   logic          i_valid;
   logic          o_next;
   logic [31:0]   o_instr;
   logic [31:0]   o_pc;
   logic          o_valid;
   logic          i_next;
   logic          c_flush;
   logic [AW:0]   o_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] sb [$];

   instr_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_instr (i_instr),
      .i_pc    (i_pc),
      .i_valid (i_valid),
      .o_next  (o_next),
      .o_instr (o_instr),
      .o_pc    (o_pc),
      .o_valid (o_valid),
      .i_next  (i_next),
      .c_flush (c_flush),
      .o_count (o_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Reference model: a plain FIFO of accepted {instr, pc} pairs.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sb.delete();
      end else if (c_flush) begin
         sb.delete();
      end else begin
         bit acc;
         acc = i_valid && (sb.size() < DEPTH);
         if (i_next && sb.size() > 0)
            void'(sb.pop_front());
         if (acc)
            sb.push_back({i_instr, i_pc});
      end
   end

   // Monitor: compare DUT outputs with the model away from the clock edge.
   always @(negedge clk) begin
      chk("o_valid", 64'(o_valid), 64'(sb.size() != 0));
      chk("o_next",  64'(o_next),  64'(sb.size() != DEPTH));
      chk("o_count", 64'(o_count), 64'(sb.size()));
      if (sb.size() != 0) begin
         chk("o_instr", 64'(o_instr), 64'(sb[0][63:32]));
         chk("o_pc",    64'(o_pc),    64'(sb[0][31:0]));
      end
   end

   task automatic cyc(input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic nx,
                      input logic fl);
      i_valid = v;
      i_pc    = pc;
      i_instr = ins;
      i_next  = nx;
      c_flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc);
      cyc(1'b1, pc, pc ^ 32'h0000_0013, 1'b0, 1'b0);
   endtask

   task automatic pop();
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      i_valid = 1'b0;
      i_pc = '0;
      i_instr = '0;
      i_next = 1'b0;
      c_flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      cyc(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
      pop();
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) push(32'(i * 4));
      push(32'h10);
      for (int i = 0; i < 4; i++) pop();

      push(32'h0);
      for (int i = 1; i < 10; i++)
         cyc(1'b1, 32'(i * 4), 32'(i * 4) ^ 32'h13, 1'b1, 1'b0);
      pop();

      for (int i = 0; i < 3; i++) push(32'h20 + 32'(i * 4));
      cyc(1'b1, 32'h40, 32'h40, 1'b0, 1'b1);
      push(32'h80);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      pop();

      for (int i = 0; i < 4; i++) push(32'h200 + 32'(i * 4));
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 32'h300 + 32'(i * 4), 32'h300 + 32'(i), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) pop();

      push(32'h500);
      push(32'h504);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(o_valid), 64'd0);
      chk("async_rst_count", 64'(o_count), 64'd0);
      chk("async_rst_next",  64'(o_next),  64'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      push(32'h100);
      pop();

      for (int n = 0; n < 600; n++) begin
         logic [31:0] r;
         r = $urandom;
         cyc(($urandom % 4) != 0, r & 32'hFFFF_FFFC, $urandom,
             ($urandom % 3) != 0, ($urandom % 40) == 0);
      end
      for (int n = 0; n < 200; n++) begin
         cyc(($urandom % 4) == 0, $urandom, $urandom, 1'b0,
             ($urandom % 50) == 0);
      end
      for (int i = 0; i < DEPTH + 1; i++) pop();

      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
# instr_queue

Instruction queue between the `fetch` stage and the `decode` stage. It buffers fetched instruction/PC pairs in a small FIFO so that fetch can keep issuing memory reads while decode stalls. A control flush discards all buffered entries when the pipeline redirects.

## Interface

Parameters:
- `DEPTH`, 4: number of entries. Must be a power of two, at least 2.
- `AW`, 2: pointer width, equal to log2(DEPTH).

Ports:
- `clk`  in  1  pipeline clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_instr`  in  32  instruction word from fetch.
- `i_pc`  in  32  PC of `i_instr`.
- `i_valid`  in  1  fetch presents a valid instruction.
- `o_next`  out  1  queue can accept an entry this cycle.
- `o_instr`  out  32  head-entry instruction to decode.
- `o_pc`  out  32  head-entry PC to decode.
- `o_valid`  out  1  head entry valid.
- `i_next`  in  1  decode accepts the head entry this cycle.
- `c_flush`  in  1  discard all entries.
- `o_count`  out  AW+1  number of occupied entries, 0..DEPTH.

## Operation

- **Storage:** circular buffer of DEPTH entries, each {instr[31:0], pc[31:0]}.
  - Write pointer `wp` and read pointer `rp` are AW bits wide and wrap modulo DEPTH.
  - Occupancy register `cnt` is AW+1 bits wide.
- **Push:** occurs when `i_valid && o_next`. The entry is written at `wp`, then `wp` increments.
- **Pop:** occurs when `o_valid && i_next`. `rp` increments. Entry contents are not cleared.
- **`o_next`:** equals `cnt != DEPTH`, derived combinationally from registered state only.
  - There is no same-cycle pass-through when full: a pop in the full cycle does not enable a push in that cycle.
- **`o_valid`:** equals `cnt != 0`.
- **`o_instr`/`o_pc`:** the entry at `rp` (show-ahead). Their values are don't-care when `o_valid=0`.
- **`cnt` update:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- **`o_count`:** equals `cnt`.
- **Flush:** when `c_flush=1` at a rising edge:
  - `wp`, `rp` and `cnt` all go to 0.
  - A push or pop in the same cycle is ignored; the flush has priority.
  - The entry presented by fetch in that cycle is dropped.
- **Reset:** while `rst=1`, `wp=rp=cnt=0` immediately, independent of `clk`.
  - Storage RAM contents are not reset.
  - An in-flight push or pop is lost.
- **Legal input behaviour:**
  - `i_valid` with `o_next=0` is legal. No write occurs, and upstream must hold the entry.
  - `i_next` with `o_valid=0` is legal. No pointer change occurs.
- **Storage implementation:** flops or LUT-RAM; no block RAM.

## Timing

- **Reset values:**
  - `o_valid=0`, `o_next=1`, `o_count=0`.
  - `o_instr`/`o_pc` show the entry at address 0 (unspecified contents).
- **Latency:** a push at edge N into an empty queue gives `o_valid=1` with that entry on `o_instr`/`o_pc` after edge N, i.e. one cycle of latency.
- **Throughput:** one push and one pop per cycle sustained when 0 < `cnt` < DEPTH.
- **Full:** `o_next` drops in the cycle after the edge that made `cnt=DEPTH`. It rises in the cycle after the first pop.
- **Empty:** `o_valid` drops in the cycle after the edge that made `cnt=0`.
- **Wrap-around:** after DEPTH pushes, `wp` returns to 0. Ordering is strictly FIFO across the wrap.
- **Flush:** in the cycle after the flush edge, `o_valid=0`, `o_next=1` and `o_count=0`. A push on the next edge is accepted normally.
- **Flush held high:** the queue stays empty for every edge at which `c_flush=1`.
- **Output path:** outputs depend only on registered state. There is no combinational path from `i_*` or `c_flush` to any output.

## Test plan

- **Reset then single entry:** assert `rst`, release it, then push {instr=0x00500093, pc=0x0}. Expect `o_valid=1`, `o_instr=0x00500093`, `o_pc=0x0` and `o_count=1` on the next cycle. Pop it and expect `o_valid=0`, `o_count=0`.
- **Fill with decode stalled:** hold `i_next=0` and push pc=0x0,0x4,0x8,0xC.
  - Expect `o_count=4` and `o_next=0`.
  - A fifth push attempt (pc=0x10) must not be written.
  - Then pop 4 times and expect pcs 0x0,0x4,0x8,0xC in order.
- **Streaming across wrap:** push and pop every cycle for 10 cycles with pc=0x0..0x24 step 4.
  - `o_count` stays 1.
  - Output pcs arrive in order across the pointer wrap.
- **Flush with simultaneous push:** with 3 entries queued, assert `c_flush` for one edge while `i_valid=1` (pc=0x40).
  - Next cycle: `o_valid=0`, `o_count=0`, `o_next=1`.
  - A following push of pc=0x80 appears at the head one cycle later.
- **Simultaneous push/pop when full:** with the queue full, hold `i_valid=1` and `i_next=1`.
  - First edge: pop only, so `o_count` goes 4→3.
  - Second edge: push and pop together, so `o_count` stays 3.
  - FIFO order is preserved.
- **Mid-operation reset:** with 2 entries queued, assert `rst` asynchronously between edges.
  - `o_valid` drops and `o_count=0` immediately, without waiting for an edge.
  - After release, the first push (pc=0x100) appears at the head.
